sdram_arbit: RTL and testbench

Command arbiter and sequencer for the 100 MHz SDRAM controller. It sits between the initialisation, auto-refresh, write and read sub-blocks inside `sdram_top` and the SDRAM pins. It owns the refresh interval timer, latches single-cycle write/read triggers, and grants the SDRAM bus to one sub-block at a time. It multiplexes the granted sub-block's command, bank and address onto the SDRAM interface.

---
 rtl/sdram_arbit_if.sv | 50 +++++
 rtl/sdram_arbit.sv | 146 ++++++++++++++
 tb/tb_sdram_arbit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - Sub-block handshake and SDRAM pin bundle for sdram_arbit
//
// Purpose: groups the sub-block trigger/end/grant handshakes, the per-sub-block
// command/address/bank buses and the muxed SDRAM pin outputs.
// Modports:
//   master - arbiter view: takes triggers, ends and sub-block buses; drives
//            grant pulses, ref_break, ref_miss and the SDRAM pins.
//   slave  - sub-block/pin view: the mirror image of master.
interface sdram_arbit_if;
    logic        init_end;
    logic        wr_trig;
    logic        rd_trig;
    logic        ref_end;
    logic        wr_end;
    logic        rd_end;
    logic [3:0]  init_cmd;
    logic [3:0]  ref_cmd;
    logic [3:0]  wr_cmd;
    logic [3:0]  rd_cmd;
    logic [12:0] init_addr;
    logic [12:0] ref_addr;
    logic [12:0] wr_addr;
    logic [12:0] rd_addr;
    logic [1:0]  wr_bank;
    logic [1:0]  rd_bank;
    logic        ref_en;
    logic        wr_en;
    logic        rd_en;
    logic        ref_break;
    logic        ref_miss;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;

    modport master (
        input  init_end, wr_trig, rd_trig, ref_end, wr_end, rd_end,
        input  init_cmd, ref_cmd, wr_cmd, rd_cmd,
        input  init_addr, ref_addr, wr_addr, rd_addr, wr_bank, rd_bank,
        output ref_en, wr_en, rd_en, ref_break, ref_miss,
        output sdram_cmd, sdram_addr, sdram_bank
    );

    modport slave (
        output init_end, wr_trig, rd_trig, ref_end, wr_end, rd_end,
        output init_cmd, ref_cmd, wr_cmd, rd_cmd,
        output init_addr, ref_addr, wr_addr, rd_addr, wr_bank, rd_bank,
        input  ref_en, wr_en, rd_en, ref_break, ref_miss,
        input  sdram_cmd, sdram_addr, sdram_bank
    );
endinterface

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter, refresh timer and bus multiplexer
//
// Purpose: owns the refresh interval timer, latches write/read triggers, grants
// the SDRAM bus to one sub-block at a time (refresh > write > read) and muxes
// the granted sub-block's command/address/bank onto the pins.
// Ports:
//   sclk  - system clock, rising edge
//   s_rst - synchronous active-high reset
//   bus   - sdram_arbit_if.master (handshakes, sub-block buses, SDRAM pins)
module sdram_arbit #(
    parameter int REF_CYCLES = 780
) (
    input  logic          sclk,
    input  logic          s_rst,
    sdram_arbit_if.master bus
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam logic [11:0] REF_LAST = 12'(REF_CYCLES - 1);
    localparam logic [3:0]  CMD_NOP  = 4'b0111;

    state_t      state_q, state_d;
    logic [11:0] timer_q, timer_d;
    logic        ref_req_q, ref_req_d;
    logic        wr_pend_q, wr_pend_d;
    logic        rd_pend_q, rd_pend_d;
    logic        ref_miss_q, ref_miss_d;
    logic        ref_en_q, ref_en_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;

    logic        grant_ref, grant_wr, grant_rd;
    logic        timer_wrap;

    // State register
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q    <= ST_INIT;
            timer_q    <= '0;
            ref_req_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            ref_miss_q <= 1'b0;
            ref_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ref_req_q  <= ref_req_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            ref_miss_q <= ref_miss_d;
            ref_en_q   <= ref_en_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
        end
    end

    // Next-state logic, refresh timer and request latches
    always_comb begin
        state_d   = state_q;
        grant_ref = 1'b0;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;

        case (state_q)
            ST_INIT:  if (bus.init_end) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (ref_req_q) begin
                    grant_ref = 1'b1;
                    state_d   = ST_AREF;
                end else if (wr_pend_q) begin
                    grant_wr = 1'b1;
                    state_d  = ST_WRITE;
                end else if (rd_pend_q) begin
                    grant_rd = 1'b1;
                    state_d  = ST_READ;
                end
            end
            ST_AREF:  if (bus.ref_end) state_d = ST_ARBIT;
            ST_WRITE: if (bus.wr_end)  state_d = ST_ARBIT;
            ST_READ:  if (bus.rd_end)  state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase

        timer_wrap = (state_q != ST_INIT) && (timer_q == REF_LAST);
        if (state_q == ST_INIT || timer_wrap) timer_d = '0;
        else                                  timer_d = timer_q + 12'd1;

        // A new expiry takes precedence over a clearing grant in the same cycle.
        ref_req_d  = timer_wrap | (ref_req_q & ~grant_ref);
        ref_miss_d = ref_miss_q | (timer_wrap & ref_req_q);

        // A trigger coincident with the grant keeps the latch set, queuing a second burst.
        wr_pend_d  = bus.wr_trig | (wr_pend_q & ~grant_wr);
        rd_pend_d  = bus.rd_trig | (rd_pend_q & ~grant_rd);

        // Grants are registered so *_en lines up with the first cycle of the new state.
        ref_en_d   = grant_ref;
        wr_en_d    = grant_wr;
        rd_en_d    = grant_rd;
    end

    // Output logic
    always_comb begin
        bus.sdram_cmd  = CMD_NOP;
        bus.sdram_addr = '0;
        bus.sdram_bank = 2'b00;
        case (state_q)
            ST_INIT: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            ST_AREF: begin
                bus.sdram_cmd  = bus.ref_cmd;
                bus.sdram_addr = bus.ref_addr;
            end
            ST_WRITE: begin
                bus.sdram_cmd  = bus.wr_cmd;
                bus.sdram_addr = bus.wr_addr;
                bus.sdram_bank = bus.wr_bank;
            end
            ST_READ: begin
                bus.sdram_cmd  = bus.rd_cmd;
                bus.sdram_addr = bus.rd_addr;
                bus.sdram_bank = bus.rd_bank;
            end
            default: ;
        endcase

        bus.ref_break = ref_req_q && (state_q == ST_WRITE || state_q == ST_READ);
        bus.ref_en    = ref_en_q;
        bus.wr_en     = wr_en_q;
        bus.rd_en     = rd_en_q;
        bus.ref_miss  = ref_miss_q;
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - Self-checking bench for sdram_arbit
module tb_sdram_arbit;

    logic sclk;
    logic s_rst;
    int   cyc;
    int   checks;
    int   errors;

    logic [18:0] exp_q[$];

    sdram_arbit_if b();

    sdram_arbit #(.REF_CYCLES(16)) dut (
        .sclk  (sclk),
        .s_rst (s_rst),
        .bus   (b.master)
    );

    localparam logic [2:0] K_REF = 3'b100;
    localparam logic [2:0] K_WR  = 3'b010;
    localparam logic [2:0] K_RD  = 3'b001;

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] kind, input int c);
        exp_q.push_back({kind, 16'(c)});
    endtask

    // Grant monitor: every *_en pulse is compared against the scoreboard
    initial begin
        logic [18:0] obs;
        logic [18:0] exp;
        forever begin
            @(negedge sclk);
            if (b.ref_en || b.wr_en || b.rd_en) begin
                obs = {b.ref_en, b.wr_en, b.rd_en, 16'(cyc)};
                exp = (exp_q.size() == 0) ? 19'd0 : exp_q.pop_front();
                chk("grant", 32'(obs), 32'(exp));
            end
        end
    end

    // Refresh sub-block stand-in: ref_end two cycles after ref_en
    initial begin
        b.ref_end = 1'b0;
        forever begin
            @(negedge sclk);
            if (b.ref_en) begin
                @(posedge sclk);
                @(posedge sclk);
                #1 b.ref_end = 1'b1;
                @(posedge sclk);
                #1 b.ref_end = 1'b0;
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        s_rst = 1'b1;
        b.init_end = 1'b0;
        b.wr_trig = 1'b0;
        b.rd_trig = 1'b0;
        b.wr_end = 1'b0;
        b.rd_end = 1'b0;
        b.init_cmd = 4'b0010;  b.init_addr = 13'h0400;
        b.ref_cmd  = 4'b0001;  b.ref_addr  = 13'h1fff;
        b.wr_cmd   = 4'b0100;  b.wr_addr   = 13'h00aa;  b.wr_bank = 2'b10;
        b.rd_cmd   = 4'b0101;  b.rd_addr   = 13'h1555;  b.rd_bank = 2'b01;

        goto(3);
        chk("rst_mux", {b.sdram_cmd, b.sdram_addr, b.sdram_bank}, {4'b0010, 13'h0400, 2'b00});
        chk("rst_flags", {b.ref_en, b.wr_en, b.rd_en, b.ref_break, b.ref_miss}, 5'b0);
        goto(5);
        s_rst = 1'b0;

        goto(20);
        chk("init_mux", {b.sdram_cmd, b.sdram_addr, b.sdram_bank}, {4'b0010, 13'h0400, 2'b00});
        b.init_end = 1'b1;
        push(K_REF, 38);
        goto(21);
        chk("arbit_nop", {b.sdram_cmd, b.sdram_addr, b.sdram_bank}, {4'b0111, 13'h0, 2'b00});
        goto(39);
        chk("aref_mux", {b.sdram_cmd, b.sdram_addr, b.sdram_bank}, {4'b0001, 13'h1fff, 2'b00});

        goto(50);
        b.wr_trig = 1'b1;
        push(K_WR, 52);
        goto(51);
        b.wr_trig = 1'b0;
        goto(52);
        chk("break_pre", 32'(b.ref_break), 32'd0);
        goto(53);
        chk("write_mux", {b.sdram_cmd, b.sdram_addr, b.sdram_bank}, {4'b0100, 13'h00aa, 2'b10});
        goto(55);
        chk("break_wr", 32'(b.ref_break), 32'd1);
        goto(62);
        b.wr_end = 1'b1;
        push(K_REF, 64);
        push(K_REF, 70);
        goto(63);
        b.wr_end = 1'b0;
        chk("post_wr_nop", {b.sdram_cmd, b.sdram_addr, b.sdram_bank}, {4'b0111, 13'h0, 2'b00});

        goto(74);
        b.wr_trig = 1'b1;
        b.rd_trig = 1'b1;
        push(K_WR, 76);
        goto(75);
        b.wr_trig = 1'b0;
        b.rd_trig = 1'b0;
        goto(80);
        b.wr_end = 1'b1;
        push(K_RD, 82);
        goto(81);
        b.wr_end = 1'b0;
        goto(84);
        chk("break_rd_pre", 32'(b.ref_break), 32'd0);
        goto(86);
        chk("read_mux", {b.sdram_cmd, b.sdram_addr, b.sdram_bank}, {4'b0101, 13'h1555, 2'b01});
        chk("break_rd", 32'(b.ref_break), 32'd1);
        goto(90);
        b.rd_end = 1'b1;
        push(K_REF, 92);
        goto(91);
        b.rd_end = 1'b0;
        chk("break_arbit", 32'(b.ref_break), 32'd0);

        goto(96);
        chk("miss_clean", 32'(b.ref_miss), 32'd0);
        b.rd_trig = 1'b1;
        push(K_RD, 98);
        goto(97);
        b.rd_trig = 1'b0;
        goto(116);
        chk("miss_before", 32'(b.ref_miss), 32'd0);
        goto(117);
        chk("miss_set", 32'(b.ref_miss), 32'd1);
        goto(130);
        b.rd_end = 1'b1;
        push(K_REF, 132);
        push(K_REF, 136);
        goto(131);
        b.rd_end = 1'b0;

        goto(139);
        b.wr_trig = 1'b1;
        push(K_WR, 141);
        goto(140);
        chk("miss_sticky", 32'(b.ref_miss), 32'd1);
        push(K_WR, 145);
        goto(141);
        b.wr_trig = 1'b0;
        goto(143);
        b.wr_end = 1'b1;
        goto(144);
        b.wr_end = 1'b0;
        b.rd_trig = 1'b1;
        goto(145);
        b.rd_trig = 1'b0;
        goto(147);
        s_rst = 1'b1;
        b.init_end = 1'b0;
        goto(148);
        s_rst = 1'b0;
        chk("rst_mid_mux", {b.sdram_cmd, b.sdram_addr, b.sdram_bank}, {4'b0010, 13'h0400, 2'b00});
        chk("rst_mid_flags", {b.ref_break, b.ref_miss}, 2'b00);
        goto(152);
        b.init_end = 1'b1;
        push(K_REF, 170);

        goto(180);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
